// File: rtl/alu_pkg.sv
// alu_pkg: op codes, engine state encoding and op classification shared by alu_mdu and md_engine
package alu_pkg;
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_SRL   = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;
  typedef enum logic {ST_IDLE, ST_RUN} md_state_t;
  function automatic logic is_md(input logic [3:0] op);
    return op >= OP_MULT && op <= OP_DIVU;
  endfunction
endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: op/operand request and result/HI/LO response bundle of the execute unit (ovf only with ALU_MDU_OVF_EN)
interface alu_mdu_if #(parameter int WIDTH = 32, parameter int SHW = 5);
  logic             in_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   s;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;
  logic             md_done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef ALU_MDU_OVF_EN
  logic             ovf;
`endif
  modport master(output in_valid, op, a, b, s,
                 input result, result_valid, busy, md_done, hi, lo
`ifdef ALU_MDU_OVF_EN
                 , input ovf
`endif
                 );
  modport slave(input in_valid, op, a, b, s,
                output result, result_valid, busy, md_done, hi, lo
`ifdef ALU_MDU_OVF_EN
                , output ovf
`endif
                );
endinterface

// File: rtl/md_engine.sv
// md_engine: iterative shift-add multiplier / restoring divider, one step per cycle, owning HI/LO
module md_engine import alu_pkg::*; #(parameter int WIDTH = 32, parameter int SHW = 5) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_t state, state_n;
  logic [SHW-1:0] cnt;
  logic [WIDTH-1:0] x, y, m, nx, ny, mag_a, mag_b, hi_n, lo_n;
  logic [WIDTH:0] sum, t, diff;
  logic [2*WIDTH-1:0] prod;
  logic is_div, neg_q, neg_r, dz, sgn, last, go;
  assign sgn = op == OP_MULT || op == OP_DIV;
  assign mag_a = sgn && a[WIDTH-1] ? -a : a;
  assign mag_b = sgn && b[WIDTH-1] ? -b : b;
  assign go = start && state == ST_IDLE;
  assign last = cnt == SHW'(WIDTH - 1);
  assign busy = state == ST_RUN;
  // one multiply or divide step, then sign fix-up of the final step's outcome
  always_comb begin
    sum = {1'b0, x} + {1'b0, y[0] ? m : '0};
    t = {x, y[WIDTH-1]};
    diff = t - {1'b0, m};
    nx = is_div ? (diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    ny = is_div ? {y[WIDTH-2:0], !diff[WIDTH]} : {sum[0], y[WIDTH-1:1]};
    prod = neg_q ? -{nx, ny} : {nx, ny};
    hi_n = is_div ? (neg_r ? -nx : nx) : prod[2*WIDTH-1:WIDTH];
    lo_n = is_div ? (dz ? '1 : neg_q ? -ny : ny) : prod[WIDTH-1:0];
  end
  // engine state: accept when idle, run WIDTH steps, then return
  always_comb begin
    state_n = state;
    if (state == ST_IDLE && start) state_n = ST_RUN;
    if (state == ST_RUN && last) state_n = ST_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_n;
  // operand latch, iteration datapath, counter and HI/LO write on the last step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {x, y, m, hi, lo} <= '0;
      cnt <= '0;
      {is_div, neg_q, neg_r, dz, md_done} <= '0;
    end else begin
      md_done <= busy && last;
      if (go) begin
        x <= '0;
        y <= mag_a;
        m <= mag_b;
        cnt <= '0;
        is_div <= op == OP_DIV || op == OP_DIVU;
        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= sgn && a[WIDTH-1];
        dz <= b == '0;
      end else if (busy) begin
        x <= nx;
        y <= ny;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi <= hi_n;
          lo <= lo_n;
        end
      end
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage registered ALU plus iterative mult/div engine; ALU_MDU_OVF_EN adds a signed add/sub overflow flag
module alu_mdu import alu_pkg::*; #(parameter int WIDTH = 32, parameter int SHW = 5) (
  input logic      clk,
  input logic      reset,
  alu_mdu_if.slave bus
);
  logic [WIDTH-1:0] alu_y;
  logic alu_go, md_go;
  assign md_go = bus.in_valid && is_md(bus.op);
  assign alu_go = bus.in_valid && !is_md(bus.op);
  // combinational ALU; MD and reserved codes yield zero
  always_comb begin
    alu_y = '0;
    case (bus.op)
      OP_ADD:  alu_y = bus.a + bus.b;
      OP_SUB:  alu_y = bus.a - bus.b;
      OP_OR:   alu_y = bus.a | bus.b;
      OP_SRL:  alu_y = bus.b >> bus.s;
      OP_SLL:  alu_y = bus.b << bus.s;
      OP_XOR:  alu_y = bus.a ^ bus.b;
      OP_AND:  alu_y = bus.a & bus.b;
      OP_SRA:  alu_y = $signed(bus.b) >>> bus.a[SHW-1:0];
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_NOR:  alu_y = ~(bus.a | bus.b);
      default: alu_y = '0;
    endcase
  end
`ifdef ALU_MDU_OVF_EN
  logic ovf_n;
  assign ovf_n = bus.op == OP_ADD ? bus.a[WIDTH-1] == bus.b[WIDTH-1] && alu_y[WIDTH-1] != bus.a[WIDTH-1] :
                 bus.op == OP_SUB ? bus.a[WIDTH-1] != bus.b[WIDTH-1] && alu_y[WIDTH-1] != bus.a[WIDTH-1] : 1'b0;
  // overflow flag registered alongside the result
  always_ff @(posedge clk or negedge reset)
    if (!reset) bus.ovf <= 1'b0;
    else if (alu_go) bus.ovf <= ovf_n;
`endif
  // result register holds until the next ALU op; valid pulses for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.result <= '0;
      bus.result_valid <= 1'b0;
    end else begin
      bus.result_valid <= alu_go;
      if (alu_go) bus.result <= alu_y;
    end
  end
  md_engine #(.WIDTH(WIDTH), .SHW(SHW)) u_md (
    .clk(clk), .reset(reset), .start(md_go), .op(bus.op), .a(bus.a), .b(bus.b),
    .busy(bus.busy), .md_done(bus.md_done), .hi(bus.hi), .lo(bus.lo)
  );
endmodule
